// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width (never below one bit).
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - c, with borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ c;
    assign bo = (~x & (y | c)) | (y & c);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single cell.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;
    logic             ovf_q, ovf_d;

    logic cell_d, cell_bo;
    logic accept, last;

    // A new operation may start from IDLE or in the single DONE cycle.
    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (cnt_q == LAST);

    fs_cell u_cell (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .c  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: load on accept, shift one bit per RUN cycle,
    // capture results on the final bit.
    always_comb begin
        cnt_d     = cnt_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        brw_d     = brw_q;
        diff_d    = diff_q;
        bo_d      = bo_q;
        ovf_d     = ovf_q;
        if (accept) begin
            a_sr_d    = a;
            b_sr_d    = b;
            brw_d     = bin;
            cnt_d     = '0;
            diff_sr_d = '0;
        end else if (state_q == RUN) begin
            a_sr_d    = a_sr_q >> 1;
            b_sr_d    = b_sr_q >> 1;
            diff_sr_d = {cell_d, diff_sr_q[WIDTH-1:1]};
            brw_d     = cell_bo;
            cnt_d     = cnt_q + CW'(1);
            if (last) begin
                diff_d = {cell_d, diff_sr_q[WIDTH-1:1]};
                bo_d   = cell_bo;
                // On the last bit the shift registers hold the operand MSBs.
                ovf_d  = (a_sr_q[0] != b_sr_q[0]) && (cell_d != a_sr_q[0]);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            brw_q     <= 1'b0;
            diff_q    <= '0;
            bo_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            brw_q     <= brw_d;
            diff_q    <= diff_d;
            bo_q      <= bo_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bo   = bo_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial, parametrised N-bit subtractor that computes `diff = a - b - bin` one bit per clock, LSB first. It reuses a single full-subtractor cell and a registered borrow. It is the successor to our single-bit combinational full subtractor and targets area-constrained datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake brackets each operation. Borrow-in/borrow-out let instances chain into wider words.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 2.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request an operation; sampled only when not busy.
- `a`, input, WIDTH: minuend; captured when start is accepted.
- `b`, input, WIDTH: subtrahend; captured when start is accepted.
- `bin`, input, 1: borrow-in; captured when start is accepted.
- `busy`, output, 1: high while the operation is in progress.
- `done`, output, 1: one-cycle pulse when the result becomes valid.
- `diff`, output, WIDTH: result `a - b - bin` modulo 2^WIDTH.
- `bo`, output, 1: borrow-out, i.e. unsigned `a < b + bin`.
- `ovf`, output, 1: signed two's-complement overflow.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on `start`.
  - RUN -> DONE after bit WIDTH-1 is processed.
  - DONE -> RUN if `start` is high in that cycle, otherwise DONE -> IDLE.
- On accept, latch `a` and `b` into shift registers, load the borrow flop with `bin`, and clear the bit counter (width $clog2(WIDTH)).
- Each RUN cycle:
  - Cell inputs are (a_sr[0], b_sr[0], borrow).
  - Cell difference bit shifts into the MSB of diff_sr, and diff_sr shifts right.
  - Cell borrow is registered.
  - a_sr and b_sr shift right.
  - The counter increments.
- Cell equations:
  - d = x ^ y ^ c
  - bo = (~x & (y | c)) | (y & c)
- On the last RUN cycle:
  - `bo` takes the final cell borrow.
  - `ovf` = (a_msb != b_msb) && (d_msb != a_msb), where a_msb and b_msb are the latched operand MSBs.
- `diff`, `bo` and `ovf` are driven from result registers. They update only on entering DONE and hold until the next operation completes.
- `start` while `busy` is ignored. Input changes after accept have no effect.
- All arithmetic is unsigned modulo 2^WIDTH. `ovf` interprets the operands as signed.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `diff`=0, `bo`=0, `ovf`=0; counter, borrow and shift registers all 0.
- Edge E0 samples `start`=1 in IDLE. `busy` is 1 after E0.
- Edges E1 through E(WIDTH) process bits 0 through WIDTH-1.
- After E(WIDTH):
  - `done`=1 and `busy`=0.
  - `diff`, `bo` and `ovf` are valid.
  - Latency from start sample to `done` visible is WIDTH cycles.
- `done` is high for exactly one cycle.
- Back-to-back: `start` in the DONE cycle is accepted. The next result appears WIDTH cycles later, giving a throughput of one result per WIDTH+1 cycles.
- `rst` has priority over everything, including mid-RUN. It returns the block to IDLE with all outputs 0 on the next edge, and no `done` is emitted for the aborted operation.
- `rst` and `start` high in the same cycle: reset wins and `start` is dropped.

## Structure
- Shared package `sub_pkg` holds:
  - The FSM state enum (IDLE, RUN, DONE).
  - A helper function for the counter width.
- One sub-module, `fs_cell`: a purely combinational 1-bit full subtractor with inputs x, y, c and outputs d, bo. It has no internal state.
- The top level contains the FSM, counter, three shift registers, the borrow flop and the result registers.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- a=0x5A, b=0x3C, bin=0 -> `diff`=0x1E, `bo`=0, `ovf`=0; `done` pulses exactly 8 cycles after start and lasts one cycle.
- a=0x00, b=0x01, bin=0 -> `diff`=0xFF, `bo`=1, `ovf`=0.
- a=0x10, b=0x0F, bin=1 -> `diff`=0x00, `bo`=0. Chained case: two instances computing 16-bit 0x1000-0x0001 -> low result 0xFF with `bo`=1, high result 0x0F.
- a=0x80, b=0x01 -> `diff`=0x7F, `ovf`=1, `bo`=0. Also a=0x7F, b=0xFF -> `diff`=0x80, `ovf`=1, `bo`=1.
- Assert `start` with new operands during RUN -> ignored, original result delivered. Assert `rst` at cycle 4 of RUN -> no `done`, all outputs 0, next start behaves normally.
- WIDTH=4 exhaustive over a, b, bin, with back-to-back starts in the DONE cycle -> every result matches the reference model, and `done` spacing is 5 cycles.
